// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes shared with the ALU control decoder, and the
// state encoding of the multicycle execute-stage ALU.
package alu_pkg;

  // ALU control codes produced by the ALU control decoder.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_MUL = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;

  typedef enum logic {
    StIdle = 1'b0,
    StMul  = 1'b1
  } alu_state_e;

  function automatic logic is_mul(input logic [2:0] ctrl);
    return ctrl == ALU_MUL;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier, one partial product per cycle,
// exactly WIDTH steps (no early termination). Returns the low WIDTH bits.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      asynchronous reset, active low
//   start_i    load operands, clear accumulator and counter, begin stepping
//   flush_i    abandon the running multiply
//   mcand_i    multiplicand (operand A)
//   mplier_i   multiplier (operand B)
//   done_o     high in the cycle whose closing edge completes the last step
//   product_o  accumulator including this cycle's step; valid when done_o
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [CntW-1:0]  cnt_q;
  logic             run_q;
  logic             last_step;

  // Bits shifted out of the multiplicand only affect product bits >= WIDTH.
  assign acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign last_step = run_q && (cnt_q == LastStep);
  assign done_o    = last_step && !flush_i;
  assign product_o = acc_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= mcand_i;
      mplier_q <= mplier_i;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b1;
    end else if (run_q) begin
      if (flush_i) begin
        run_q <= 1'b0;
      end else begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CntW'(1);
        if (last_step) begin
          run_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: execute-stage ALU. ADD/SUB/AND/OR (and undefined codes,
// which yield 0) complete at the accepting edge; MUL runs WIDTH shift-add
// steps in alu_mul_iter while busy_o stalls the pipeline.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      asynchronous reset, active low
//   valid_i    operation request
//   ready_o    request can be accepted this cycle (idle)
//   ALUCtrl_i  op code: 000 add, 001 sub, 010 mul, 011 and, 100 or
//   data1_i    operand A (rs)
//   data2_i    operand B (rt)
//   flush_i    abort in-flight or requested op
//   data_o     result, held until the next completion
//   zero_o     data_o == 0, registered with data_o
//   valid_o    one-cycle pulse per completed op
//   busy_o     multiply in progress
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             valid_o,
  output logic             busy_o
);

  alu_state_e       state_q;
  logic [WIDTH-1:0] data_q;
  logic             zero_q;
  logic             valid_q;

  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] single_res;

  assign ready_o   = (state_q == StIdle);
  assign busy_o    = (state_q == StMul);
  // Flush wins over a simultaneous request.
  assign accept    = valid_i && ready_o && !flush_i;
  assign mul_start = accept && is_mul(ALUCtrl_i);

  assign data_o  = data_q;
  assign zero_o  = zero_q;
  assign valid_o = valid_q;

  // Single-cycle datapath; undefined codes produce 0.
  always_comb begin
    single_res = '0;
    case (ALUCtrl_i)
      ALU_ADD: single_res = data1_i + data2_i;
      ALU_SUB: single_res = data1_i - data2_i;
      ALU_AND: single_res = data1_i & data2_i;
      ALU_OR:  single_res = data1_i | data2_i;
      default: single_res = '0;
    endcase
  end

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul_iter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (mul_start),
    .flush_i   (flush_i),
    .mcand_i   (data1_i),
    .mplier_i  (data2_i),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      data_q  <= '0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (is_mul(ALUCtrl_i)) begin
              state_q <= StMul;
            end else begin
              data_q  <= single_res;
              zero_q  <= (single_res == '0);
              valid_q <= 1'b1;
            end
          end
        end
        StMul: begin
          if (flush_i) begin
            state_q <= StIdle;
          end else if (mul_done) begin
            data_q  <= mul_product;
            zero_q  <= (mul_product == '0);
            valid_q <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed cases followed by random
// ops, checked against a plain-arithmetic reference model.
module tb_alu_multicycle;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic         valid_in;
  logic         ready;
  logic [2:0]   ctrl;
  logic [W-1:0] data1;
  logic [W-1:0] data2;
  logic         flush;
  logic [W-1:0] data_out;
  logic         zero;
  logic         valid_out;
  logic         busy;

  int unsigned  n_assert;
  int unsigned  n_fail;
  logic [W-1:0] exp_data;

  alu_multicycle #(
    .WIDTH (W)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_n),
    .valid_i   (valid_in),
    .ready_o   (ready),
    .ALUCtrl_i (ctrl),
    .data1_i   (data1),
    .data2_i   (data2),
    .flush_i   (flush),
    .data_o    (data_out),
    .zero_o    (zero),
    .valid_o   (valid_out),
    .busy_o    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: results modulo 2^W, computed with plain arithmetic.
  function automatic logic [W-1:0] ref_result(input logic [2:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    logic [2*W-1:0] p;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return p[W-1:0];
      end
      3'd3: return a & b;
      3'd4: return a | b;
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output checks for the cycle right after a completion.
  task automatic chk_done(input string tag);
    chk({tag, " valid"}, W'(valid_out), W'(1));
    chk({tag, " data"}, data_out, exp_data);
    chk({tag, " zero"}, W'(zero), W'(exp_data == '0));
    chk({tag, " ready"}, W'(ready), W'(1));
  endtask

  task automatic do_single(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] exp);
    data1    = a;
    data2    = b;
    ctrl     = op;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    exp_data = exp;
    chk_done(tag);
    tick();
    chk({tag, " valid low"}, W'(valid_out), W'(0));
    chk({tag, " hold"}, data_out, exp_data);
  endtask

  // Multiply: busy for W cycles, valid in cycle W+1 after accept. Operands,
  // op code and valid_i are scrambled while busy and must be ignored.
  task automatic do_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp);
    data1    = a;
    data2    = b;
    ctrl     = 3'b010;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    for (int i = 1; i <= int'(W); i++) begin
      chk({tag, " busy/ready/valid"}, W'({busy, ready, valid_out}), W'(3'b100));
      data1    = $urandom;
      data2    = $urandom;
      ctrl     = 3'($urandom_range(0, 7));
      valid_in = 1'($urandom_range(0, 1));
      tick();
    end
    valid_in = 1'b0;
    exp_data = exp;
    chk_done(tag);
    chk({tag, " not busy"}, W'(busy), W'(0));
    tick();
    chk({tag, " valid low"}, W'(valid_out), W'(0));
  endtask

  initial begin
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;

    n_assert = 0;
    n_fail   = 0;
    exp_data = '0;
    rst_n    = 1'b1;
    valid_in = 1'b0;
    flush    = 1'b0;
    ctrl     = 3'b000;
    data1    = '0;
    data2    = '0;

    #1 rst_n = 1'b0;
    #2;
    chk("reset data", data_out, '0);
    chk("reset flags", W'({zero, valid_out, busy, ready}), W'(4'b1001));
    tick();
    tick();
    rst_n = 1'b1;
    chk("post-reset flags", W'({zero, valid_out, busy, ready}), W'(4'b1001));

    // Back-to-back single-cycle ops.
    data1    = 32'd5;
    data2    = 32'd7;
    ctrl     = 3'b000;
    valid_in = 1'b1;
    tick();
    exp_data = 32'd12;
    chk_done("add 5+7");
    data1 = 32'd7;
    data2 = 32'd7;
    ctrl  = 3'b001;
    tick();
    valid_in = 1'b0;
    exp_data = 32'd0;
    chk_done("sub 7-7");
    tick();
    chk("sub valid low", W'(valid_out), W'(0));

    do_mul("mul ffff*10001", 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF);
    do_mul("mul -3*4", 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFF4);
    do_single("sub 0-1", 3'b001, 32'd0, 32'd1, 32'hFFFF_FFFF);
    do_single("add wrap", 3'b000, 32'hFFFF_FFFF, 32'd1, 32'd0);
    do_single("and", 3'b011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
    do_single("or", 3'b100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0);
    do_single("code 111", 3'b111, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0);
    do_single("add 9+0", 3'b000, 32'd9, 32'd0, 32'd9);

    // Flush in cycle 10 of a multiply.
    data1    = 32'h0000_1234;
    data2    = 32'h0000_5678;
    ctrl     = 3'b010;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    chk("flush pre busy", W'({busy, ready}), W'(2'b10));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush mul flags", W'({busy, ready, valid_out}), W'(3'b010));
    chk("flush mul data", data_out, exp_data);
    tick();
    chk("flush mul no late valid", W'(valid_out), W'(0));
    do_single("add 1+1", 3'b000, 32'd1, 32'd1, 32'd2);

    // Requests with flush in idle are dropped.
    data1    = 32'd3;
    data2    = 32'd4;
    ctrl     = 3'b000;
    valid_in = 1'b1;
    flush    = 1'b1;
    tick();
    chk("idle flush add valid", W'(valid_out), W'(0));
    chk("idle flush add data", data_out, exp_data);
    ctrl = 3'b010;
    tick();
    valid_in = 1'b0;
    flush    = 1'b0;
    chk("idle flush mul flags", W'({busy, ready, valid_out}), W'(3'b010));
    tick();
    chk("idle flush mul data", data_out, exp_data);

    // Asynchronous reset between edges of a multiply.
    data1    = 32'd9;
    data2    = 32'd9;
    ctrl     = 3'b010;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    exp_data = '0;
    chk("async rst data", data_out, '0);
    chk("async rst flags", W'({zero, valid_out, busy, ready}), W'(4'b1001));
    #1 rst_n = 1'b1;
    tick();
    chk("after rst flags", W'({zero, valid_out, busy, ready}), W'(4'b1001));
    do_mul("mul 6*7", 32'd6, 32'd7, 32'd42);

    // Random ops against the reference model.
    for (int n = 0; n < 30; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      if (op == 3'b010) do_mul("rand mul", a, b, ref_result(op, a, b));
      else do_single("rand op", op, a, b, ref_result(op, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Execute-stage ALU. Consumes the 3-bit ALU control code from the ALU control decoder, plus two operands from the ID/EX path.
- ADD, SUB, AND and OR complete in one cycle.
- MUL runs as an iterative shift-add sequence over WIDTH cycles.
- Uses a valid/ready handshake so the pipeline controller can stall upstream while a multiply is in flight.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- valid_i  input  1  operation request.
- ready_o  output  1  block can accept a request this cycle.
- ALUCtrl_i  input  3  op code: 000 add, 001 sub, 010 mul, 011 and, 100 or.
- data1_i  input  WIDTH  operand A (rs).
- data2_i  input  WIDTH  operand B (rt).
- flush_i  input  1  abort any in-flight or requested op.
- data_o  output  WIDTH  result.
- zero_o  output  1  data_o == 0.
- valid_o  output  1  one-cycle pulse; data_o/zero_o are new.
- busy_o  output  1  multiply in progress (stall request to hazard unit).

Behaviour:
- Reset (rst_i low, async): state IDLE, data_o=0, zero_o=1, valid_o=0, busy_o=0, ready_o=1, counter=0.
- ready_o = (state==IDLE). A request is accepted at an edge where valid_i && ready_o && !flush_i.
- States: IDLE, MUL.
- IDLE, accept of code 000/001/011/100:
  - Result is registered at the accepting edge; valid_o=1 the following cycle; latency 1; stays in IDLE.
  - Back-to-back accepts are allowed every cycle.
- IDLE, accept of 010: latch A into the multiplicand register and B into the multiplier register; clear the accumulator and counter; go to MUL; busy_o=1, ready_o=0.
- MUL, each edge:
  - If multiplier LSB is set, add the multiplicand to the accumulator.
  - Shift the multiplicand left 1 and the multiplier right 1; counter++.
  - At the edge where counter reaches WIDTH: data_o = accumulator (low WIDTH bits), valid_o=1 next cycle, go to IDLE.
  - Total latency from accept to valid_o is WIDTH+1 cycles (33 at default). No early termination.
- Arithmetic:
  - All results are modulo 2^WIDTH. Add/sub wrap silently; no overflow flag.
  - MUL returns the low WIDTH bits of the product; the result is the same signed or unsigned.
- Undefined codes 101/110/111: accepted as single-cycle ops with result 0, so zero_o=1 and valid_o pulses.
- zero_o is registered together with data_o and always reflects the held data_o.
- data_o and zero_o hold their last value until the next completion.
- valid_o is high for exactly one cycle per completed op, and 0 in every other cycle.
- flush_i:
  - In MUL: return to IDLE on that edge; no valid_o; data_o keeps its previous value.
  - In IDLE together with valid_i: the request is dropped.
  - Flush wins over any simultaneous accept.
- Operand inputs are ignored while in MUL. Changing them mid-multiply must not affect the result.
- Async reset asserted mid-multiply: immediately to the reset values; the partial product is discarded.

Decomposition:
- Package alu_pkg holds:
  - ALU control code constants: ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_MUL=3'b010, ALU_AND=3'b011, ALU_OR=3'b100. These are shared with the ALU control decoder.
  - The state encoding (IDLE=0, MUL=1).
- Sub-module alu_mul_iter holds the multiplicand/multiplier/accumulator registers, counter and done strobe, with start, flush, done and product ports.
- The top level holds the single-cycle datapath, state register and handshake.

Test Plan:
- Reset, then ADD 5+7, then SUB 7-7 on consecutive cycles -> data_o=12, zero_o=0, valid_o at cycle 1; then data_o=0, zero_o=1, valid_o at cycle 2.
- MUL 0x0000FFFF * 0x00010001 -> busy_o=1 and ready_o=0 for 32 cycles; data_o=0xFFFFFFFF, valid_o exactly 33 cycles after accept; operands toggled during MUL have no effect.
- MUL -3 (0xFFFFFFFD) * 4 -> data_o=0xFFFFFFF4. SUB 0 - 1 -> 0xFFFFFFFF. ADD 0xFFFFFFFF + 1 -> 0, zero_o=1.
- AND 0xF0F0F0F0 & 0x0FF00FF0 -> 0x00F000F0. OR of the same operands -> 0xFFF0FFF0. Code 111 -> 0, zero_o=1, valid_o pulses.
- flush_i at cycle 10 of a MUL -> no valid_o, data_o unchanged, ready_o=1 next cycle; a following ADD 1+1 -> 2 at latency 1. valid_i with flush_i in IDLE -> no accept.
- rst_i dropped asynchronously mid-MUL (between edges) -> outputs at reset values immediately; after release, a MUL 6*7 -> 42.
